// File: rtl/dump_control.sv
// dump_control -- sequences the squeeze/output side of a Keccak core.
// It accepts squeezed rate blocks, loads them into the output buffer,
// drains the buffer word by word over a valid/ready port, and pulses done
// once the requested number of output bits has been produced.
// Optional feature: define DUMP_CONTROL_PREFETCH_EN to capture the next
// rate block while the current one is still being drained.
module dump_control #(
   // Mode code that selects the 1088-bit rate; every other mode uses 1344.
   parameter logic [1:0] SHAKE256_MODE_VEC = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] output_size,
   input  logic [1:0]  operation_mode,
   input  logic        block_valid,
   output logic        block_ready,
   input  logic        output_buffer_empty,
   output logic        intermediate_buffer_we,
   output logic        output_buffer_we,
   output logic        output_buffer_shift_en,
   output logic        output_counter_load,
   output logic        output_counter_rst,
   output logic        valid_bytes_reset,
   output logic        valid_bytes_enable,
   output logic        last_output_block,
   output logic [31:0] remaining_size,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_BLOCK = 3'd1,
      LOAD       = 3'd2,
      DRAIN      = 3'd3,
      DONE       = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] remaining_q, remaining_d;
   logic [1:0]  mode_q, mode_d;
   logic        inter_full_q, inter_full_d;
   logic        last_q, last_d;

   // Moore outputs are registered from the next state so they change
   // cleanly on the clock edge.
   logic        busy_q;
   logic        done_q;
   logic        dout_valid_q;
   logic        load_q;

   logic [31:0] rate;
   logic        last_now;
   logic        accept;
   logic        handshake;
   logic        job_start;
   logic        ready_int;

   assign rate      = (mode_q == SHAKE256_MODE_VEC) ? 32'd1088 : 32'd1344;
   assign last_now  = (remaining_q <= rate);
   assign accept    = block_valid && ready_int;
   assign handshake = dout_valid_q && dout_ready;
   // Gated by rst so nothing toggles while the block is held in reset.
   assign job_start = rst && (state_q == IDLE) && start && (output_size != 32'd0);

`ifdef DUMP_CONTROL_PREFETCH_EN
   // While draining a non-final block the intermediate buffer is free, so
   // the next block can be captured in parallel with the drain.
   assign ready_int = ((state_q == WAIT_BLOCK) && !inter_full_q) ||
                      ((state_q == DRAIN) && !inter_full_q && !last_q);
`else
   assign ready_int = (state_q == WAIT_BLOCK) && !inter_full_q;
`endif

   // Next-state and datapath-register update logic.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      mode_d       = mode_q;
      inter_full_d = inter_full_q | accept;
      last_d       = last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (output_size != 32'd0) begin
                  remaining_d = output_size;
                  mode_d      = operation_mode;
                  state_d     = WAIT_BLOCK;
               end else begin
                  state_d = DONE;
               end
            end
         end
         WAIT_BLOCK: begin
            if (inter_full_q || accept) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            // The intermediate buffer is copied into the output buffer here.
            inter_full_d = 1'b0;
            last_d       = last_now;
            remaining_d  = last_now ? 32'd0 : (remaining_q - rate);
            state_d      = DRAIN;
         end
         DRAIN: begin
            if (handshake && output_buffer_empty) begin
               last_d = 1'b0;
               if (last_q) begin
                  state_d = DONE;
               end else begin
`ifdef DUMP_CONTROL_PREFETCH_EN
                  state_d = (inter_full_q || accept) ? LOAD : WAIT_BLOCK;
`else
                  state_d = WAIT_BLOCK;
`endif
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, job registers and registered Moore outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         remaining_q  <= 32'd0;
         mode_q       <= 2'b00;
         inter_full_q <= 1'b0;
         last_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         load_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         mode_q       <= mode_d;
         inter_full_q <= inter_full_d;
         last_q       <= last_d;
         busy_q       <= (state_d != IDLE);
         done_q       <= (state_d == DONE);
         dout_valid_q <= (state_d == DRAIN);
         load_q       <= (state_d == LOAD);
      end
   end

   assign block_ready            = ready_int;
   assign intermediate_buffer_we = accept;
   assign output_buffer_we       = load_q;
   assign output_counter_load    = load_q;
   assign valid_bytes_enable     = load_q;
   assign output_buffer_shift_en = handshake;
   assign output_counter_rst     = job_start;
   assign valid_bytes_reset      = job_start;
   // Visible while the block is loaded and held for the whole drain.
   assign last_output_block      = (state_q == LOAD) ? last_now
                                 : ((state_q == DRAIN) && last_q);
   assign remaining_size         = remaining_q;
   assign dout_valid             = dout_valid_q;
   assign busy                   = busy_q;
   assign done                   = done_q;

endmodule

// File: tb/tb_dump_control.sv
// Directed, table-driven bench for dump_control plus hand-written
// multi-block, prefetch and reset sequences.
module tb_dump_control;

   localparam logic [1:0] M128 = 2'b10;
   localparam logic [1:0] M256 = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] output_size;
   logic [1:0]  operation_mode;
   logic        block_valid;
   logic        block_ready;
   logic        output_buffer_empty;
   logic        ib_we, ob_we, ob_shift, cnt_load, cnt_rst, vb_reset, vb_enable, last_blk;
   logic [31:0] remaining_size;
   logic        dout_valid;
   logic        dout_ready;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   // {block_ready, ib_we, ob_we, shift, cnt_load, cnt_rst, vb_reset, vb_enable, last, dout_valid, busy, done}
   logic [11:0] ctl_act;
   assign ctl_act = {block_ready, ib_we, ob_we, ob_shift, cnt_load, cnt_rst,
                     vb_reset, vb_enable, last_blk, dout_valid, busy, done};

   dump_control dut (
      .clk                    (clk),
      .rst                    (rst),
      .start                  (start),
      .output_size            (output_size),
      .operation_mode         (operation_mode),
      .block_valid            (block_valid),
      .block_ready            (block_ready),
      .output_buffer_empty    (output_buffer_empty),
      .intermediate_buffer_we (ib_we),
      .output_buffer_we       (ob_we),
      .output_buffer_shift_en (ob_shift),
      .output_counter_load    (cnt_load),
      .output_counter_rst     (cnt_rst),
      .valid_bytes_reset      (vb_reset),
      .valid_bytes_enable     (vb_enable),
      .last_output_block      (last_blk),
      .remaining_size         (remaining_size),
      .dout_valid             (dout_valid),
      .dout_ready             (dout_ready),
      .busy                   (busy),
      .done                   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] sz;
      logic [1:0]  m;
      logic        bv;
      logic        dr;
      logic        obe;
      logic [11:0] ctl;
      logic [31:0] rem;
   } vec_t;

   vec_t vq[$];

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Apply inputs on the falling edge and let outputs settle before checks.
   task automatic drive(input logic s, input logic [31:0] sz, input logic [1:0] m,
                        input logic bv, input logic dr, input logic obe);
      @(negedge clk);
      start               = s;
      output_size         = sz;
      operation_mode      = m;
      block_valid         = bv;
      dout_ready          = dr;
      output_buffer_empty = obe;
      #1;
   endtask

   initial begin
      int ib_cnt;
      int shift_cnt;
      logic prefetch;
`ifdef DUMP_CONTROL_PREFETCH_EN
      prefetch = 1'b1;
`else
      prefetch = 1'b0;
`endif

      // SHAKE128, 256 bits, one block, 4 words; start outside IDLE ignored.
      vq.push_back('{1'b1, 32'd256, M128, 1'b0, 1'b0, 1'b0, 12'b0000_0110_0000, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b1, 1'b0, 1'b0, 12'b1100_0000_0010, 32'd256});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b0010_1001_1010, 32'd256});
      vq.push_back('{1'b1, 32'd99,  M128, 1'b0, 1'b1, 1'b0, 12'b0001_0000_1110, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b1, 1'b0, 12'b0001_0000_1110, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b1, 1'b0, 12'b0001_0000_1110, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b1, 1'b1, 12'b0001_0000_1110, 32'd0});
      vq.push_back('{1'b1, 32'd5,   M256, 1'b0, 1'b0, 1'b0, 12'b0000_0000_0011, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b0000_0000_0000, 32'd0});
      // SHAKE256, 8 bits, late block, 5-cycle dout_ready stall, zero-size job.
      vq.push_back('{1'b1, 32'd8,   M256, 1'b0, 1'b0, 1'b0, 12'b0000_0110_0000, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b1000_0000_0010, 32'd8});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b1, 1'b0, 1'b0, 12'b1100_0000_0010, 32'd8});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b0010_1001_1010, 32'd8});
      for (int k = 0; k < 5; k++)
         vq.push_back('{1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b1, 12'b0000_0000_1110, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b1, 1'b1, 12'b0001_0000_1110, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b0000_0000_0011, 32'd0});
      vq.push_back('{1'b1, 32'd0,   M256, 1'b1, 1'b0, 1'b0, 12'b0000_0000_0000, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b1, 1'b0, 1'b0, 12'b0000_0000_0011, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b1, 1'b0, 1'b0, 12'b0000_0000_0000, 32'd0});
      // SHAKE256, exactly one rate (1088): last block boundary.
      vq.push_back('{1'b1, 32'd1088, M256, 1'b0, 1'b0, 1'b0, 12'b0000_0110_0000, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b1, 1'b0, 1'b0, 12'b1100_0000_0010, 32'd1088});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b0010_1001_1010, 32'd1088});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b1, 1'b1, 12'b0001_0000_1110, 32'd0});
      vq.push_back('{1'b0, 32'd0,   M128, 1'b0, 1'b0, 1'b0, 12'b0000_0000_0011, 32'd0});

      // Reset state.
      rst = 1'b0; start = 1'b0; output_size = 32'd0; operation_mode = 2'b00;
      block_valid = 1'b0; dout_ready = 1'b0; output_buffer_empty = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check12("reset_ctl", ctl_act, 12'b0);
      check32("reset_rem", remaining_size, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].s, vq[i].sz, vq[i].m, vq[i].bv, vq[i].dr, vq[i].obe);
         check12($sformatf("vec%0d_ctl", i), ctl_act, vq[i].ctl);
         check32($sformatf("vec%0d_rem", i), remaining_size, vq[i].rem);
      end

      // SHAKE256, 1152 bits: 17 words then 1 word, block_valid held high.
      drive(1'b1, 32'd1152, M256, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
      check1("j2_wait_ibwe", ib_we, 1'b1);
      drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
      check1("j2_load1_obwe", ob_we, 1'b1);
      check1("j2_load1_last", last_blk, 1'b0);
      check32("j2_load1_rem", remaining_size, 32'd1152);
      ib_cnt = 0;
      shift_cnt = 0;
      for (int w = 1; w <= 17; w++) begin
         drive(1'b0, 32'd0, M128, 1'b1, 1'b1, (w == 17));
         if (ob_shift) shift_cnt++;
         if (ib_we) ib_cnt++;
         if (w == 1) check32("j2_drain1_rem", remaining_size, 32'd64);
      end
      check32("j2_drain1_words", shift_cnt, 17);
      check32("j2_drain1_prefetch_we", ib_cnt, prefetch ? 1 : 0);
      if (!prefetch) begin
         drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
         check1("j2_wait2_ibwe", ib_we, 1'b1);
      end
      drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
      check1("j2_load2_obwe", ob_we, 1'b1);
      check1("j2_load2_last", last_blk, 1'b1);
      check32("j2_load2_rem", remaining_size, 32'd64);
      check1("j2_load2_bready", block_ready, 1'b0);
      drive(1'b0, 32'd0, M128, 1'b1, 1'b1, 1'b1);
      check1("j2_drain2_shift", ob_shift, 1'b1);
      check1("j2_drain2_bready", block_ready, 1'b0);
      check1("j2_drain2_last", last_blk, 1'b1);
      drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
      check1("j2_done", done, 1'b1);
      drive(1'b0, 32'd0, M128, 1'b0, 1'b0, 1'b0);
      check1("j2_idle_done", done, 1'b0);
      check1("j2_idle_busy", busy, 1'b0);

      // Asynchronous reset in the middle of a drain.
      drive(1'b1, 32'd256, M128, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 32'd0, M128, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'd0, M128, 1'b1, 1'b0, 1'b0);
      check1("rst_pre_dvalid", dout_valid, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b0; start = 1'b1; output_size = 32'd64; block_valid = 1'b1;
      dout_ready = 1'b1; output_buffer_empty = 1'b1;
      #1;
      check12("rst_mid_ctl", ctl_act, 12'b0);
      check32("rst_mid_rem", remaining_size, 32'd0);
      drive(1'b0, 32'd0, M128, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 32'd0, M128, 1'b0, 1'b0, 1'b0);
         check1($sformatf("rst_after%0d_done", c), done, 1'b0);
         check1($sformatf("rst_after%0d_busy", c), busy, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
